// File: rtl/word_bus_pkg.sv
// Shared types and constants for the 32-bit word bus initiator.
package word_bus_pkg;

  localparam int WORD_W      = 32;
  localparam int DEF_MAX_LEN = 8;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

endpackage

// File: rtl/word_bus_rd_stage.sv
// Read output register: holds one bus word for the downstream valid/ready port
// and tells the burst FSM when another bus read may be issued.
module word_bus_rd_stage
  import word_bus_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_last,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_last,
  output logic              can_accept,
  output logic              pop
);

  logic              vld_p0;
  logic [WORD_W-1:0] data_p0;
  logic              last_p0;

  assign pop        = vld_p0 && rd_ready;
  assign can_accept = !vld_p0 || rd_ready;

  // Stage p0: captured bus word, visible one cycle after its bus_ren cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      last_p0 <= 1'b0;
    end else if (load) begin
      vld_p0  <= 1'b1;
      data_p0 <= load_data;
      last_p0 <= load_last;
    end else if (pop) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end
  end

  assign rd_valid = vld_p0;
  assign rd_data  = data_p0;
  assign rd_last  = last_p0;

endmodule

// File: rtl/word_burst_master.sv
// Burst initiator for the shared 32-bit word bus (write drain / read stream).
// Optional window check enabled by defining WORD_BURST_MASTER_RANGE_CHECK_EN.
module word_burst_master
  import word_bus_pkg::*;
#(
  parameter int                MAX_LEN  = DEF_MAX_LEN,
  parameter logic [WORD_W-1:0] WIN_BASE = 32'd0,
  parameter int                WIN_NBR  = 32,
  localparam int               LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [WORD_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WORD_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_last,
  output logic [WORD_W-1:0] bus_wraddr,
  output logic [WORD_W-1:0] bus_wrdata,
  output logic              bus_wen,
  output logic [WORD_W-1:0] bus_rdaddr,
  output logic              bus_ren,
  input  logic [WORD_W-1:0] bus_rddata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int EXT_W = WORD_W + 1;

  state_t            state;
  logic [WORD_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  count;
  logic              more;
  logic              last_word;
  logic              wr_fire;
  logic              cmd_reject;
  logic              can_accept;
  logic              pop;
  logic [WORD_W-1:0] cur_addr;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign more      = (count < len);
  assign last_word = ((count + 1'b1) == len);
  assign cur_addr  = addr + WORD_W'(count);
  assign wr_ready  = (state == WRITE) && more;
  assign wr_fire   = wr_valid && wr_ready;
  assign bus_ren   = (state == READ) && more && can_accept;
  assign bus_rdaddr = bus_ren ? cur_addr : '0;

`ifdef WORD_BURST_MASTER_RANGE_CHECK_EN
  logic [EXT_W-1:0] win_end;
  logic [EXT_W-1:0] cmd_end;
  // Widened sums so a command that wraps past 2^32 is out of range
  assign win_end    = {1'b0, WIN_BASE} + EXT_W'(WIN_NBR);
  assign cmd_end    = {1'b0, cmd_addr} + EXT_W'(cmd_len);
  assign cmd_reject = (cmd_addr < WIN_BASE) || (cmd_end > win_end);
`else
  logic unused_win;
  assign unused_win = ^{WIN_BASE, WIN_NBR, EXT_W};
  assign cmd_reject = 1'b0;
`endif

  word_bus_rd_stage u_rd_stage (
    .clk        (clk),
    .reset      (reset),
    .load       (bus_ren),
    .load_data  (bus_rddata),
    .load_last  (last_word),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .can_accept (can_accept),
    .pop        (pop)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      len        <= '0;
      count      <= '0;
      bus_wen    <= 1'b0;
      bus_wraddr <= '0;
      bus_wrdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      bus_wen <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_reject) begin
              err <= 1'b1;
            end else begin
              addr  <= cmd_addr;
              len   <= cmd_len;
              count <= '0;
              if (cmd_len == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= cmd_write ? WRITE : READ;
              end
            end
          end
        end
        WRITE: begin
          if (wr_fire) begin
            bus_wen    <= 1'b1;
            bus_wraddr <= cur_addr;
            bus_wrdata <= wr_data;
            count      <= count + 1'b1;
          end else if (!more) begin
            // The final bus_wen cycle is in progress now
            state <= DONE;
            done  <= 1'b1;
          end
        end
        READ: begin
          if (bus_ren) count <= count + 1'b1;
          if (pop && rd_last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/word_burst_master.md
# word_burst_master

Initiator for the shared 32-bit word bus used by our biased-address register files and the serial/parallel word buffers. It accepts a burst command (base address, length, direction). It then either drains an upstream valid/ready stream into consecutive bus writes, or issues consecutive bus reads and returns the data on a downstream valid/ready stream. It sits between the host-side command/stream logic and the register-file address space.

## Interface
- MAX_LEN, 8: maximum burst length in words; `cmd_len` width is $clog2(MAX_LEN+1).
- WIN_BASE, 32'd0: first legal word address (used only with range check).
- WIN_NBR, 32: number of legal words from WIN_BASE (used only with range check).

Reset is synchronous and active-high, and the clock is `clk`.
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  32  first word address
- cmd_len  in  $clog2(MAX_LEN+1)  word count; 0 is legal
- wr_valid / wr_ready  in / out  1  upstream write-data handshake
- wr_data  in  32  write word
- rd_valid / rd_ready  out / in  1  downstream read-data handshake
- rd_data  out  32  read word
- rd_last  out  1  marks final word of a read burst
- bus_wraddr, bus_wrdata  out  32  bus write address/data
- bus_wen  out  1  bus write strobe
- bus_rdaddr  out  32  bus read address
- bus_ren  out  1  bus read enable
- bus_rddata  in  32  bus read data, combinational w.r.t. bus_rdaddr/bus_ren
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at burst end
- err  out  1  one-cycle pulse on rejected command

## Operation
- States are IDLE, WRITE, READ and DONE.
- **IDLE:**
  - cmd_ready=1.
  - On cmd_valid, latch addr and len and clear the count.
  - Go to WRITE or READ per cmd_write.
  - If len==0, go straight to DONE with no bus activity.
- **WRITE:**
  - wr_ready = (count < len).
  - On a wr handshake, register bus_wraddr=addr+count, bus_wrdata=wr_data, and set bus_wen=1 for exactly the next cycle. Then increment count.
  - When the last word's bus_wen cycle is issued, go to DONE.
- **READ:**
  - bus_ren=1 with bus_rdaddr=addr+count when (count < len) and (output register empty or rd_ready this cycle).
  - Capture bus_rddata into rd_data at that edge. Set rd_valid=1 and rd_last=(count==len-1), then increment count.
  - When the rd handshake with rd_last=1 occurs, go to DONE.
- **DONE:** done=1 for one cycle, then go to IDLE.
- **Address arithmetic:** addr+count is 32-bit modulo 2^32; 32'hFFFFFFFF+1 wraps to 0.
- **Reset mid-burst:** state returns to IDLE and the in-flight word is dropped. bus_wen or bus_ren is not asserted in the cycle after reset.
- **Reset values:** all outputs are 0 except cmd_ready=1.
- **Commands outside IDLE:** not accepted; cmd_ready is low.

## Timing
- Cmd handshake at edge k: state is WRITE/READ during cycle k+1.
- **Write:**
  - A wr handshake at edge j gives bus_wen=1 in cycle j+1.
  - The register file updates at edge j+2.
  - Throughput is 1 word/cycle with wr_valid held high.
  - done rises in the cycle after the last bus_wen cycle.
- **Read:**
  - bus_ren is asserted in cycle k+1 and rd_valid in cycle k+2.
  - Throughput is 1 word/cycle with rd_ready held high.
  - rd_ready low stalls bus_ren, so no word is lost or duplicated.
- **Zero-length burst:** done in cycle k+1.

## Configuration
- WORD_BURST_MASTER_RANGE_CHECK_EN defined:
  - A command is rejected when cmd_addr < WIN_BASE or cmd_addr+cmd_len > WIN_BASE+WIN_NBR. These are 33-bit compares, so wrap-around counts as out of range.
  - A rejected command is still handshaken (cmd_ready=1). err pulses one cycle later, the state stays IDLE, and there is no bus activity and no done.
- Macro undefined: no check, err tied 0, and WIN_BASE and WIN_NBR are unused.

## Structure
- Package word_bus_pkg holds:
  - the state enum (IDLE, WRITE, READ, DONE);
  - WORD_W=32;
  - the default MAX_LEN.
- One sub-module, word_bus_rd_stage: the read output register with rd_valid/rd_last, load-enable and pop logic. It exposes "can accept" to the FSM to gate bus_ren.

## Test plan
- Write burst addr=4, len=3, data A0,A1,A2 with wr_valid held high -> bus_wen cycles k+2..k+4 at addresses 4,5,6; done in cycle k+5.
- Read burst addr=4, len=3 against a model regfile, rd_ready=1 -> rd_data A0,A1,A2 on consecutive cycles, rd_last on A2, then done.
- Read len=4 with rd_ready toggling 1,0,0,1,... -> exact order, no drops or duplicates, and bus_ren low while the output is full and not popped.
- len=0 read and write -> no bus_wen/bus_ren; done in cycle k+1.
- addr=32'hFFFFFFFE, len=3 write (macro off) -> addresses FFFFFFFE, FFFFFFFF, 0. With the macro on (WIN_BASE=0, WIN_NBR=32), expect an err pulse and no bus activity; addr=30, len=2 is accepted.
- Reset asserted in the second word of a 4-word read -> next cycle idle, cmd_ready=1, all outputs 0. A following burst behaves normally.
